mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter and sequencer for the single-port 256x16 data/instruction RAM. It shares the RAM between the CPU memory interface (port C) and a program/data loader port (port L). Each port uses a req/gnt/valid handshake. The block sits in the top level between the CPU, the loader and the RAM. It owns every RAM control signal.

Parameters:
ADDR_W, 8, RAM word-address width (256 words)
DATA_W, 16, RAM word width
MAX_WAIT, 4, number of consecutive lost arbitrations after which L wins over C (starvation limit, 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  C request, held until cpu_gnt seen
cpu_we  input  1  C write (1) / read (0)
cpu_addr  input  ADDR_W  C word address
cpu_wdata  input  DATA_W  C write data
cpu_gnt  output  1  one-cycle pulse: C request captured
cpu_valid  output  1  one-cycle pulse: C transaction complete
cpu_rdata  output  DATA_W  C read data, held until next C read completes
ld_req, ld_we, ld_addr, ld_wdata  input  1/1/ADDR_W/DATA_W  L request, same rules as C
ld_gnt, ld_valid  output  1  L equivalents of cpu_gnt/cpu_valid
ld_rdata  output  DATA_W  L read data
mem_addr  output  ADDR_W  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM registered read data, valid one cycle after address presented
busy  output  1  high when state != IDLE

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - All gnt/valid outputs go to 0; rdata registers go to 0; mem_addr/mem_wdata go to 0.
  - mem_we is 0 immediately, not at the next edge; it is decoded from state, and an in-flight write is dropped.
  - Starvation counter goes to 0.
- States: IDLE, ISSUE, RESP.
  - Transition order is IDLE -> ISSUE -> RESP -> IDLE; there are no other transitions.
  - Owner register (C/L) plus captured we/addr/wdata registers.
- IDLE, edge with any req high:
  - Pick the winner and capture its we/addr/wdata.
  - Set the winner's gnt to 1 for exactly one cycle and go to ISSUE.
  - No req high: stay in IDLE.
- ISSUE:
  - mem_addr and mem_wdata come from the captured registers.
  - mem_we = captured we, asserted only in this state.
  - Next edge: RAM performs the access; go to RESP.
- RESP:
  - On a read, the owner's rdata is loaded from mem_rdata at the next edge; on a write, rdata is unchanged.
  - The owner's valid is set to 1 for one cycle; go to IDLE.
- Latency:
  - Request sampled at edge E0; gnt high E0..E1; valid high E2..E3.
  - Throughput: one transaction per 3 cycles; a new request can be sampled at E3.
- Requester rules:
  - Deassert req during the gnt cycle. req is ignored outside IDLE.
  - A req still high at the next IDLE edge is treated as a new transaction.
- Arbitration:
  - C has fixed priority.
  - The counter increments on each IDLE edge where ld_req=1 and C wins.
  - When counter == MAX_WAIT and ld_req=1, L wins instead.
  - The counter clears on any L grant and whenever ld_req=0 at an IDLE edge. It saturates at MAX_WAIT.
- Simultaneous requests: both ports requesting at the same IDLE edge is resolved only by the rule above; exactly one gnt is asserted.
- Outside ISSUE: mem_we=0, while mem_addr and mem_wdata keep their last values.
- Inputs are not range-checked: addresses wrap naturally within ADDR_W.

Decomposition:
- Shared package mem_arb_pkg: state encoding localparams (IDLE/ISSUE/RESP) and owner encoding (OWN_C/OWN_L), shared with the top-level instance.
- One sub-module, mem_arb_sel: winner select plus the starvation counter.
  - Inputs: cpu_req, ld_req, arbitration enable (state==IDLE).
  - Outputs: sel_c, sel_l.
  - Registered counter inside.
- The FSM, capture registers and rdata registers stay in mem_arbiter.

Test Plan:
1. After reset release: C write 0xABCD to addr 6, then C read addr 6 -> cpu_gnt at E0..E1, cpu_valid 2 cycles later, cpu_rdata=0xABCD; mem_we high exactly one cycle.
2. L alone writes 0x0005 to addr 0, then C reads addr 0 -> cpu_rdata=0x0005; ld_valid pulses once; ld_rdata stays 0.
3. cpu_req and ld_req held high continuously, MAX_WAIT=4 -> grant order C,C,C,C,L,C,C,C,C,L; never both gnt in one cycle.
4. ld_req raised while C transaction in ISSUE -> ld_gnt at the first IDLE edge after cpu_valid; busy low only in that IDLE cycle.
5. mem[9]=0x0005; C write 0x1234 to addr 9; reset driven low mid-ISSUE -> mem_we falls without an edge, mem[9] stays 0x0005, all outputs 0, state IDLE after release.
6. Back-to-back C reads of addr 1,2,3 (values 0x0011/0x0022/0x0033) with req reasserted immediately -> three cpu_valid pulses 3 cycles apart, correct data each.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM arbiter: FSM states,
// port ownership and starvation counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_L = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, loader and RAM signal bundle of the arbiter.
// slave: arbiter side; master: requesters and RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_valid, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_valid, ld_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_valid, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_valid, ld_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter_sel.sv
// Winner select: fixed C priority, L forced through
// after MAX_WAIT consecutive lost arbitrations.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic cpu_req_i,
  input  logic ld_req_i,
  input  logic en_i,
  output logic sel_c_o,
  output logic sel_l_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             starved;

  assign starved = (cnt_q == LIMIT);
  assign sel_l_o = en_i & ld_req_i
                 & (~cpu_req_i | starved);
  assign sel_c_o = en_i & cpu_req_i & ~sel_l_o;

  // Only IDLE edges count; a pending L that loses
  // bumps the count, an absent L or an L grant clears.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (!ld_req_i || sel_l_o) begin
        cnt_d = '0;
      end else if (!starved) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a single-port RAM:
// IDLE captures a winner, ISSUE drives RAM, RESP returns.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  state_e            state_q;
  owner_e            own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cgnt_q;
  logic              lgnt_q;
  logic              cval_q;
  logic              lval_q;
  logic [DATA_W-1:0] crd_q;
  logic [DATA_W-1:0] lrd_q;
  logic              sel_c;
  logic              sel_l;
  logic              arb_en;

  assign arb_en = (state_q == IDLE);

  mem_arb_sel #(
    .MAX_WAIT (MAX_WAIT)
  ) u_sel (
    .clk       (clk),
    .rst_ni    (reset),
    .cpu_req_i (bus.cpu_req),
    .ld_req_i  (bus.ld_req),
    .en_i      (arb_en),
    .sel_c_o   (sel_c),
    .sel_l_o   (sel_l)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      own_q   <= OWN_C;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cgnt_q  <= 1'b0;
      lgnt_q  <= 1'b0;
      cval_q  <= 1'b0;
      lval_q  <= 1'b0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      cgnt_q <= 1'b0;
      lgnt_q <= 1'b0;
      cval_q <= 1'b0;
      lval_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_c || sel_l) begin
            own_q   <= sel_l ? OWN_L : OWN_C;
            we_q    <= sel_l ? bus.ld_we
                             : bus.cpu_we;
            addr_q  <= sel_l ? bus.ld_addr
                             : bus.cpu_addr;
            wdata_q <= sel_l ? bus.ld_wdata
                             : bus.cpu_wdata;
            cgnt_q  <= sel_c;
            lgnt_q  <= sel_l;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= RESP;
        end
        RESP: begin
          // RAM data is registered, so it is valid here
          if (!we_q) begin
            if (own_q == OWN_L) begin
              lrd_q <= bus.mem_rdata;
            end else begin
              crd_q <= bus.mem_rdata;
            end
          end
          cval_q  <= (own_q == OWN_C);
          lval_q  <= (own_q == OWN_L);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write enable decodes from state so reset drops it at once
  assign bus.mem_we    = (state_q == ISSUE) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_gnt   = cgnt_q;
  assign bus.ld_gnt    = lgnt_q;
  assign bus.cpu_valid = cval_q;
  assign bus.ld_valid  = lval_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.ld_rdata  = lrd_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model plus a
// transaction-level reference of memory and arbitration.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ram [256] = '{default: 16'h0};
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  logic [15:0] ref_mem [256];
  logic [15:0] ref_crd;
  logic [15:0] ref_lrd;
  int          wait_n;
  int          errors;
  int          checks;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(
    input  bit          is_l,
    input  bit          we,
    input  logic [7:0]  a,
    input  logic [15:0] d,
    output int          gcyc,
    output int          vcyc,
    output int          wecnt,
    output int          gcnt,
    output logic [15:0] rd
  );
    gcyc = -1; vcyc = -1; wecnt = 0; gcnt = 0; rd = 'x;
    if (we) ref_mem[a] = d;
    else if (is_l) ref_lrd = ref_mem[a];
    else ref_crd = ref_mem[a];
    wait_n = 0;
    if (is_l) begin
      bus.ld_req = 1; bus.ld_we = we;
      bus.ld_addr = a; bus.ld_wdata = d;
    end else begin
      bus.cpu_req = 1; bus.cpu_we = we;
      bus.cpu_addr = a; bus.cpu_wdata = d;
    end
    for (int n = 1; n <= 20 && vcyc < 0; n++) begin
      step();
      if (bus.mem_we) wecnt++;
      if (is_l ? bus.ld_gnt : bus.cpu_gnt) begin
        gcnt++;
        if (gcyc < 0) gcyc = n;
        if (is_l) bus.ld_req = 0; else bus.cpu_req = 0;
      end
      if (is_l ? bus.ld_valid : bus.cpu_valid) begin
        vcyc = n;
        rd = is_l ? bus.ld_rdata : bus.cpu_rdata;
      end
    end
    bus.cpu_req = 0;
    bus.ld_req  = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ld_req = 0; bus.ld_we = 0;
    bus.ld_addr = 0; bus.ld_wdata = 0;
    repeat (3) step();
    #3 rst_n = 1;
    step();
    checks++;
    if ({bus.cpu_gnt, bus.cpu_valid, bus.ld_gnt, bus.ld_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_gnt_valid: got %b want 0000",
        {bus.cpu_gnt, bus.cpu_valid, bus.ld_gnt, bus.ld_valid});
    end
    checks++;
    if ({bus.cpu_rdata, bus.ld_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", {bus.cpu_rdata, bus.ld_rdata});
    end
    checks++;
    if ({bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata} !== 26'h0) begin
      errors++;
      $display("FAIL reset_mem_busy: got %h want 0",
        {bus.mem_we, bus.busy, bus.mem_addr, bus.mem_wdata});
    end
  endtask

  task automatic test_cpu_rw();
    int g, v, w, gc;
    logic [15:0] rd;
    run_txn(0, 1, 8'd6, 16'hABCD, g, v, w, gc, rd);
    checks++;
    if (g !== 1 || gc !== 1) begin
      errors++;
      $display("FAIL c_wr_gnt: got cyc %0d width %0d want 1 1", g, gc);
    end
    checks++;
    if (v !== 3) begin
      errors++;
      $display("FAIL c_wr_valid_cyc: got %0d want 3", v);
    end
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL c_wr_we_cycles: got %0d want 1", w);
    end
    run_txn(0, 0, 8'd6, 16'h0, g, v, w, gc, rd);
    checks++;
    if (rd !== 16'hABCD || v !== 3) begin
      errors++;
      $display("FAIL c_rd_data: got %h at %0d want abcd at 3", rd, v);
    end
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL c_rd_we_cycles: got %0d want 0", w);
    end
  endtask

  task automatic test_loader();
    int g, v, w, gc;
    logic [15:0] rd;
    run_txn(1, 1, 8'd0, 16'h0005, g, v, w, gc, rd);
    checks++;
    if (g !== 1 || v !== 3 || w !== 1) begin
      errors++;
      $display("FAIL l_wr_timing: got %0d %0d %0d want 1 3 1", g, v, w);
    end
    step();
    checks++;
    if (bus.ld_valid !== 1'b0) begin
      errors++;
      $display("FAIL l_valid_width: got %b want 0", bus.ld_valid);
    end
    run_txn(0, 0, 8'd0, 16'h0, g, v, w, gc, rd);
    checks++;
    if (rd !== 16'h0005) begin
      errors++;
      $display("FAIL l_then_c_rd: got %h want 0005", rd);
    end
    checks++;
    if (bus.ld_rdata !== ref_lrd) begin
      errors++;
      $display("FAIL l_rdata_hold: got %h want %h", bus.ld_rdata, ref_lrd);
    end
  endtask

  // Both requesters random; L wins once it has lost MAX_WAIT times
  task automatic contend(input int ngr, input bit ld_on, output string ord);
    logic [15:0] cq[$];
    logic [15:0] lq[$];
    logic [15:0] e;
    bit          cw, lw, exp_l;
    logic [7:0]  ca, la;
    logic [15:0] cd, ldd;
    int          got;
    got = 0; ord = "";
    cw = 1'($urandom); ca = 8'($urandom); cd = 16'($urandom);
    lw = 1'($urandom); la = 8'($urandom); ldd = 16'($urandom);
    bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.ld_we = lw; bus.ld_addr = la; bus.ld_wdata = ldd;
    bus.cpu_req = 1; bus.ld_req = ld_on;
    for (int n = 0; n < ngr * 4 + 10; n++) begin
      step();
      if (bus.cpu_valid) begin
        e = (cq.size() > 0) ? cq.pop_front() : 16'hxxxx;
        checks++;
        if (bus.cpu_rdata !== e) begin
          errors++;
          $display("FAIL cont_c_rdata: got %h want %h", bus.cpu_rdata, e);
        end
      end
      if (bus.ld_valid) begin
        e = (lq.size() > 0) ? lq.pop_front() : 16'hxxxx;
        checks++;
        if (bus.ld_rdata !== e) begin
          errors++;
          $display("FAIL cont_l_rdata: got %h want %h", bus.ld_rdata, e);
        end
      end
      if (bus.cpu_gnt || bus.ld_gnt) begin
        exp_l = ld_on && (wait_n == MAX_WAIT);
        checks++;
        if (bus.ld_gnt !== exp_l || bus.cpu_gnt !== !exp_l) begin
          errors++;
          $display("FAIL cont_winner: got c=%b l=%b want l=%b",
            bus.cpu_gnt, bus.ld_gnt, exp_l);
        end
        if (exp_l || !ld_on) wait_n = 0;
        else wait_n = wait_n + 1;
        ord = {ord, bus.ld_gnt ? "L" : "C"};
        if (exp_l) begin
          if (lw) ref_mem[la] = ldd; else ref_lrd = ref_mem[la];
          lq.push_back(ref_lrd);
          lw = 1'($urandom); la = 8'($urandom); ldd = 16'($urandom);
          bus.ld_we = lw; bus.ld_addr = la; bus.ld_wdata = ldd;
        end else begin
          if (cw) ref_mem[ca] = cd; else ref_crd = ref_mem[ca];
          cq.push_back(ref_crd);
          cw = 1'($urandom); ca = 8'($urandom); cd = 16'($urandom);
          bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        end
        got++;
        if (got == ngr) begin
          bus.cpu_req = 0; bus.ld_req = 0;
        end
      end
      if (got == ngr && cq.size() == 0 && lq.size() == 0) break;
    end
    bus.cpu_req = 0; bus.ld_req = 0;
    checks++;
    if (got != ngr || cq.size() != 0 || lq.size() != 0) begin
      errors++;
      $display("FAIL cont_timeout: got %0d grants want %0d", got, ngr);
    end
  endtask

  task automatic test_contention();
    string o;
    int g, v, w, gc;
    logic [15:0] rd;
    contend(10, 1, o);
    checks++;
    if (o != "CCCCLCCCCL") begin
      errors++;
      $display("FAIL starve_order: got %s want CCCCLCCCCL", o);
    end
    contend(2, 1, o);
    run_txn(0, 0, 8'd6, 16'h0, g, v, w, gc, rd);
    contend(6, 1, o);
    checks++;
    if (o != "CCCCLC") begin
      errors++;
      $display("FAIL starve_clear: got %s want CCCCLC", o);
    end
  endtask

  task automatic test_ld_during_issue();
    int vc, lg, lv, blow;
    bit seen;
    logic [15:0] la, ld;
    vc = -1; lg = -1; lv = -1; blow = 0; seen = 0;
    ref_crd = ref_mem[8'd6];
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'd6;
    for (int n = 0; n < 10 && !seen; n++) begin
      step();
      if (bus.cpu_gnt) seen = 1;
    end
    bus.cpu_req = 0;
    la = 16'($urandom); ld = 16'($urandom);
    bus.ld_req = 1; bus.ld_we = 1;
    bus.ld_addr = la[7:0]; bus.ld_wdata = ld;
    ref_mem[la[7:0]] = ld;
    for (int n = 1; n <= 20 && lv < 0; n++) begin
      step();
      if (bus.cpu_valid) begin
        vc = n;
        checks++;
        if (bus.cpu_rdata !== ref_crd) begin
          errors++;
          $display("FAIL issue_c_rdata: got %h want %h", bus.cpu_rdata, ref_crd);
        end
      end
      if (bus.ld_gnt) begin
        lg = n; bus.ld_req = 0;
      end
      if (bus.ld_valid) lv = n;
      else if (!bus.busy) blow++;
    end
    bus.ld_req = 0;
    wait_n = 0;
    checks++;
    if (!seen || vc < 0 || lg !== vc + 1) begin
      errors++;
      $display("FAIL issue_l_gnt: got %0d want %0d", lg, vc + 1);
    end
    checks++;
    if (blow !== 1) begin
      errors++;
      $display("FAIL issue_busy_low: got %0d want 1", blow);
    end
  endtask

  task automatic test_back_to_back();
    int g, v, w, gc, k, vi;
    int vt [3];
    logic [15:0] rd;
    logic [15:0] ev [3];
    ev[0] = 16'h0011; ev[1] = 16'h0022; ev[2] = 16'h0033;
    for (int i = 0; i < 3; i++)
      run_txn(0, 1, 8'(i + 1), ev[i], g, v, w, gc, rd);
    k = 0; vi = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'd1;
    for (int n = 1; n <= 30 && vi < 3; n++) begin
      step();
      if (bus.cpu_gnt) begin
        k++;
        if (k < 3) bus.cpu_addr = 8'(k + 1);
        else bus.cpu_req = 0;
      end
      if (bus.cpu_valid) begin
        vt[vi] = n;
        checks++;
        if (bus.cpu_rdata !== ev[vi]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h want %h", vi, bus.cpu_rdata, ev[vi]);
        end
        vi++;
      end
    end
    bus.cpu_req = 0;
    ref_crd = ev[2];
    checks++;
    if (vi !== 3 || vt[1] - vt[0] !== 3 || vt[2] - vt[1] !== 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d pulses %0d %0d %0d want 3 apart",
        vi, vt[0], vt[1], vt[2]);
    end
  endtask

  task automatic test_reset_mid_issue();
    int g, v, w, gc;
    logic [15:0] rd;
    run_txn(0, 1, 8'd9, 16'h0005, g, v, w, gc, rd);
    bus.cpu_req = 1; bus.cpu_we = 1;
    bus.cpu_addr = 8'd9; bus.cpu_wdata = 16'h1234;
    step();
    bus.cpu_req = 0;
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_issue: got gnt=%b we=%b want 1 1",
        bus.cpu_gnt, bus.mem_we);
    end
    #3 rst_n = 0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_we: got %b want 0", bus.mem_we);
    end
    checks++;
    if ({bus.cpu_gnt, bus.cpu_valid, bus.ld_gnt, bus.ld_valid, bus.busy,
         bus.cpu_rdata, bus.ld_rdata, bus.mem_addr, bus.mem_wdata} !== 61'h0) begin
      errors++;
      $display("FAIL rst_async_outs: got %h want 0",
        {bus.cpu_gnt, bus.cpu_valid, bus.ld_gnt, bus.ld_valid, bus.busy,
         bus.cpu_rdata, bus.ld_rdata, bus.mem_addr, bus.mem_wdata});
    end
    repeat (2) step();
    #2 rst_n = 1;
    ref_crd = 0; ref_lrd = 0; wait_n = 0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got busy %b want 0", bus.busy);
    end
    run_txn(0, 0, 8'd9, 16'h0, g, v, w, gc, rd);
    checks++;
    if (rd !== 16'h0005) begin
      errors++;
      $display("FAIL rst_write_dropped: got %h want 0005", rd);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    ref_crd = 0; ref_lrd = 0; wait_n = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    test_reset();
    test_cpu_rw();
    test_loader();
    test_contention();
    test_ld_during_issue();
    test_back_to_back();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
